// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_pkg
// Description : Shared types and constants for the counter step sequencer:
//               FSM state encoding, step-table entry layout, control bits.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_seq_pkg;

    // Field widths of one step-table entry. The sequencer's WIDTH and REP_W
    // parameters default to these and must agree with them.
    localparam int STEP_PERIOD_W = 8;
    localparam int STEP_REP_W    = 8;

    // Position of the mode bit inside the 8-bit counter control word.
    localparam int CTRL_MODE_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One program step: counter period, mode (1 = triangle, 0 = sawtooth)
    // and number of complete count cycles minus one.
    typedef struct packed {
        logic [STEP_PERIOD_W-1:0] period;
        logic                     mode;
        logic [STEP_REP_W-1:0]    rep;
    } step_t;

endpackage
`default_nettype wire

// File: rtl/counter_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer_if
// Description : Link between the step sequencer (master) and the up/down
//               counter it drives (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] cnt_value;
    logic [WIDTH-1:0] cnt_period;
    logic [7:0]       cnt_control;
    logic             cnt_enable;
    logic             cnt_clear_n;

    modport master (
        input  cnt_value,
        output cnt_period,
        output cnt_control,
        output cnt_enable,
        output cnt_clear_n
    );

    modport slave (
        output cnt_value,
        input  cnt_period,
        input  cnt_control,
        input  cnt_enable,
        input  cnt_clear_n
    );
endinterface
`default_nettype wire

// File: rtl/counter_seq_table.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_table
// Description : DEPTH-entry step table. Synchronous write, asynchronous
//               reads (full entry on port A, period only on port B),
//               asynchronous active-low clear of all entries.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_table
    import counter_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     i_we,
    input  wire logic [AW-1:0]            i_waddr,
    input  wire step_t                    i_wdata,
    input  wire logic [AW-1:0]            i_raddr_a,
    output step_t                         o_rdata_a,
    input  wire logic [AW-1:0]            i_raddr_b,
    output logic [STEP_PERIOD_W-1:0]      o_period_b
);

    step_t r_mem [DEPTH];

    // Table storage: cleared by reset, one entry written per strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_mem[i_raddr_a];
    assign o_period_b = r_mem[i_raddr_b].period;

endmodule
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer
// Description : Programmable step sequencer for one period/control up-down
//               counter. Each table step runs the counter for (repeat+1)
//               complete count cycles, then advances; done pulses at the
//               end of the program.
//               Optional build macro COUNTER_SEQ_LOOP_EN: at end of program
//               restart from step 0 instead of finishing.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = STEP_PERIOD_W,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int REP_W = STEP_REP_W
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             cfg_we,
    input  wire logic [AW-1:0]    cfg_addr,
    input  wire logic [WIDTH-1:0] cfg_period,
    input  wire logic             cfg_mode,
    input  wire logic [REP_W-1:0] cfg_repeat,
    input  wire logic             start,
    input  wire logic             stop,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         step_idx,
    counter_sequencer_if.master   cnt
);

    state_t             r_state;
    state_t             w_next_state;
    logic [AW-1:0]      r_step_idx;
    logic [AW-1:0]      w_next_step;
    logic [REP_W-1:0]   r_rep_cnt;
    logic               r_prev_nz;
    logic [WIDTH-1:0]   r_cnt_period;
    logic [7:0]         r_cnt_control;
    logic               r_cnt_enable;
    logic               r_cnt_clear_n;
    logic               r_busy;
    logic               r_done;

    step_t              w_wdata;
    step_t              w_cur;
    logic [AW-1:0]      w_rd_addr;
    logic [AW-1:0]      w_nxt_idx;
    logic [WIDTH-1:0]   w_nxt_period;
    logic               w_table_we;
    logic               w_cmpl;
    logic               w_rep_last;
    logic               w_last;

    // In IDLE the program always starts at entry 0, whatever step_idx holds.
    assign w_rd_addr  = (r_state == IDLE) ? '0 : r_step_idx;
    assign w_nxt_idx  = r_step_idx + AW'(1);
    assign w_table_we = cfg_we && !r_busy;
    assign w_wdata    = '{period: cfg_period, mode: cfg_mode, rep: cfg_repeat};

    counter_seq_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .i_we       (w_table_we),
        .i_waddr    (cfg_addr),
        .i_wdata    (w_wdata),
        .i_raddr_a  (w_rd_addr),
        .o_rdata_a  (w_cur),
        .i_raddr_b  (w_nxt_idx),
        .o_period_b (w_nxt_period)
    );

    // A count cycle ends when the counter returns to zero after being nonzero.
    assign w_cmpl     = (r_state == RUN) && (cnt.cnt_value == '0) && r_prev_nz;
    assign w_rep_last = (r_rep_cnt == w_cur.rep);
    assign w_last     = (r_step_idx == AW'(DEPTH - 1)) || (w_nxt_period == '0);

    // State and step index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_step_idx <= '0;
        end else begin
            r_state    <= w_next_state;
            r_step_idx <= w_next_step;
        end
    end

    // Next-state and step-advance decisions.
    always_comb begin
        w_next_state = r_state;
        w_next_step  = r_step_idx;
        unique case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_next_step  = '0;
                    w_next_state = (w_cur.period == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                w_next_state = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop) begin
                    w_next_state = IDLE;
                end else if (w_cmpl && w_rep_last) begin
                    if (w_last) begin
`ifdef COUNTER_SEQ_LOOP_EN
                        w_next_step  = '0;
                        w_next_state = LOAD;
`else
                        w_next_state = DONE;
`endif
                    end else begin
                        w_next_step  = w_nxt_idx;
                        w_next_state = LOAD;
                    end
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Step datapath: latch counter setup in LOAD, track repeats in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_period  <= '0;
            r_cnt_control <= '0;
            r_rep_cnt     <= '0;
            r_prev_nz     <= 1'b0;
        end else if (r_state == LOAD) begin
            r_cnt_period                 <= w_cur.period;
            r_cnt_control                <= '0;
            r_cnt_control[CTRL_MODE_BIT] <= w_cur.mode;
            r_rep_cnt                    <= '0;
            r_prev_nz                    <= 1'b0;
        end else if (r_state == RUN) begin
            r_prev_nz <= (cnt.cnt_value != '0);
            if (w_cmpl && !w_rep_last) begin
                r_rep_cnt <= r_rep_cnt + REP_W'(1);
            end
        end
    end

    // Registered status and counter strobes, decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_enable  <= 1'b0;
            r_cnt_clear_n <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_cnt_enable  <= (w_next_state == RUN);
            r_cnt_clear_n <= (w_next_state != LOAD);
            r_busy        <= (w_next_state == LOAD) || (w_next_state == RUN);
            r_done        <= (w_next_state == DONE);
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign step_idx        = r_step_idx;
    assign cnt.cnt_period  = r_cnt_period;
    assign cnt.cnt_control = r_cnt_control;
    assign cnt.cnt_enable  = r_cnt_enable;
    assign cnt.cnt_clear_n = r_cnt_clear_n;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_counter_sequencer
// Description : Self-checking bench for counter_sequencer with a behavioural
//               counter, directed programs and a scoreboard monitor.
//               Build with COUNTER_SEQ_LOOP_EN to exercise the looping build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int REP_W = 8;
    localparam int EV_RUN  = 0;
    localparam int EV_DONE = 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_we = 1'b0;
    logic [AW-1:0]    cfg_addr = '0;
    logic [WIDTH-1:0] cfg_period = '0;
    logic             cfg_mode = 1'b0;
    logic [REP_W-1:0] cfg_repeat = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             busy;
    logic             done;
    logic [AW-1:0]    step_idx;

    always #5 clk = ~clk;

    counter_sequencer_if #(.WIDTH(WIDTH)) cnt_if ();

    counter_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW),
        .REP_W (REP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .cfg_repeat (cfg_repeat),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .step_idx   (step_idx),
        .cnt        (cnt_if)
    );

    // Behavioural counter: sawtooth 0..period then 0; triangle 0..period..0.
    logic [WIDTH-1:0] m_val;
    logic             m_down;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_val  <= '0;
            m_down <= 1'b0;
        end else if (!cnt_if.cnt_clear_n) begin
            m_val  <= '0;
            m_down <= 1'b0;
        end else if (cnt_if.cnt_enable) begin
            if (!cnt_if.cnt_control[0]) begin
                m_val <= (m_val >= cnt_if.cnt_period) ? '0 : m_val + 1'b1;
            end else if (!m_down) begin
                if (m_val >= cnt_if.cnt_period) begin
                    m_down <= 1'b1;
                    m_val  <= m_val - 1'b1;
                end else begin
                    m_val <= m_val + 1'b1;
                end
            end else begin
                if (m_val == '0) begin
                    m_down <= 1'b0;
                    m_val  <= m_val + 1'b1;
                end else begin
                    m_val <= m_val - 1'b1;
                end
            end
        end
    end
    assign cnt_if.cnt_value = m_val;

    typedef struct {
        int kind;
        int step;
        int period;
        int ctrl;
        int cmpl;
        int loads;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic ev_t ev_run(input int s, input int p, input int c);
        ev_t e;
        e = '{kind: EV_RUN, step: s, period: p, ctrl: c, cmpl: 0, loads: 0};
        return e;
    endfunction

    function automatic ev_t ev_done(input int s, input int c, input int l);
        ev_t e;
        e = '{kind: EV_DONE, step: s, period: 0, ctrl: 0, cmpl: c, loads: l};
        return e;
    endfunction

    // Monitor: counts loads and completions, checks each run start and done.
    logic mon_prev_en = 1'b0;
    logic mon_prev_nz = 1'b0;
    int   mon_cmpl = 0;
    int   mon_loads = 0;
    ev_t  mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            mon_prev_en = 1'b0;
            mon_prev_nz = 1'b0;
            mon_cmpl    = 0;
            mon_loads   = 0;
        end else begin
            if (busy && !cnt_if.cnt_clear_n) mon_loads++;
            if (cnt_if.cnt_enable) begin
                if (cnt_if.cnt_value == '0 && mon_prev_nz) mon_cmpl++;
                mon_prev_nz = (cnt_if.cnt_value != '0);
            end else begin
                mon_prev_nz = 1'b0;
            end
            if (cnt_if.cnt_enable && !mon_prev_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_run_start: got step %0d expected no event", step_idx);
                end else begin
                    mon_e = sb.pop_front();
                    chk("run_kind", EV_RUN, mon_e.kind);
                    chk("run_step", 32'(step_idx), mon_e.step);
                    chk("run_period", 32'(cnt_if.cnt_period), mon_e.period);
                    chk("run_control", 32'(cnt_if.cnt_control), mon_e.ctrl);
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no event");
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_kind", EV_DONE, mon_e.kind);
                    chk("done_step", 32'(step_idx), mon_e.step);
                    chk("done_completions", mon_cmpl, mon_e.cmpl);
                    chk("done_loads", mon_loads, mon_e.loads);
                end
                mon_cmpl  = 0;
                mon_loads = 0;
            end else if (!busy) begin
                mon_cmpl  = 0;
                mon_loads = 0;
            end
            mon_prev_en = cnt_if.cnt_enable;
        end
    end

    task automatic write_entry(input int a, input int p, input int m, input int r);
        @(posedge clk);
        #1;
        cfg_we     = 1'b1;
        cfg_addr   = AW'(a);
        cfg_period = WIDTH'(p);
        cfg_mode   = m[0];
        cfg_repeat = REP_W'(r);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int max);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_enable(input string name, input int max);
        int n;
        n = 0;
        while (!cnt_if.cnt_enable && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(cnt_if.cnt_enable), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Asynchronous reset values, before any clock edge.
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_step_idx", 32'(step_idx), 0);
        chk("rst_period", 32'(cnt_if.cnt_period), 0);
        chk("rst_control", 32'(cnt_if.cnt_control), 0);
        chk("rst_enable", 32'(cnt_if.cnt_enable), 0);
        chk("rst_clear_n", 32'(cnt_if.cnt_clear_n), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_clear_n", 32'(cnt_if.cnt_clear_n), 1);

        // Empty program: entry 0 period 0 goes straight to DONE.
        sb.push_back(ev_done(0, 0, 0));
        pulse_start();
        wait_empty("empty_program", 20);

`ifdef COUNTER_SEQ_LOOP_EN
        // Looping build: step 0 reloads repeatedly, never done, stop aborts.
        write_entry(0, 2, 0, 0);
        write_entry(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) sb.push_back(ev_run(0, 2, 0));
        pulse_start();
        wait_empty("loop_reloads", 60);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        chk("loop_stop_busy", 32'(busy), 0);
        chk("loop_stop_enable", 32'(cnt_if.cnt_enable), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("loop_idle_done", 32'(done), 0);
`else
        // Single sawtooth step.
        write_entry(0, 4, 0, 0);
        write_entry(1, 0, 0, 0);
        sb.push_back(ev_run(0, 4, 0));
        sb.push_back(ev_done(0, 1, 1));
        pulse_start();
        wait_empty("single_step", 40);
        chk("after_done_busy", 32'(busy), 0);
        chk("after_done_done", 32'(done), 0);

        // Triangle with three repeats.
        write_entry(0, 3, 1, 2);
        write_entry(1, 0, 0, 0);
        sb.push_back(ev_run(0, 3, 1));
        sb.push_back(ev_done(0, 3, 1));
        pulse_start();
        wait_empty("triangle_repeat", 80);

        // Multi-step program ending on a zero period.
        write_entry(0, 2, 0, 0);
        write_entry(1, 5, 1, 1);
        write_entry(2, 3, 0, 0);
        write_entry(3, 0, 0, 0);
        sb.push_back(ev_run(0, 2, 0));
        sb.push_back(ev_run(1, 5, 1));
        sb.push_back(ev_run(2, 3, 0));
        sb.push_back(ev_done(2, 4, 3));
        pulse_start();
        wait_empty("multi_step", 120);

        // Full table with period 1 steps, ending at the last entry.
        write_entry(0, 1, 0, 0);
        write_entry(1, 1, 1, 0);
        write_entry(2, 2, 0, 0);
        write_entry(3, 1, 0, 0);
        sb.push_back(ev_run(0, 1, 0));
        sb.push_back(ev_run(1, 1, 1));
        sb.push_back(ev_run(2, 2, 0));
        sb.push_back(ev_run(3, 1, 0));
        sb.push_back(ev_done(3, 4, 4));
        pulse_start();
        wait_empty("full_table", 80);

        // Abort in the middle of step 1.
        write_entry(0, 2, 0, 0);
        write_entry(1, 5, 1, 1);
        write_entry(2, 3, 0, 0);
        write_entry(3, 0, 0, 0);
        sb.push_back(ev_run(0, 2, 0));
        sb.push_back(ev_run(1, 5, 1));
        pulse_start();
        begin
            int n;
            n = 0;
            while (!(step_idx == 2'd1 && cnt_if.cnt_enable) && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("abort_reached_step1", 32'(step_idx), 1);
        repeat (3) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_enable", 32'(cnt_if.cnt_enable), 0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done), 0);
        chk("abort_events", sb.size(), 0);
        sb.delete();

        // Start and stop together in IDLE: stays idle.
        start = 1'b1;
        stop  = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("start_stop_busy", 32'(busy), 0);
        end
        start = 1'b0;
        stop  = 1'b0;

        // Table write while busy is dropped.
        write_entry(0, 4, 0, 0);
        write_entry(1, 0, 0, 0);
        sb.push_back(ev_run(0, 4, 0));
        sb.push_back(ev_done(0, 1, 1));
        pulse_start();
        wait_enable("guard_enable", 10);
        write_entry(0, 9, 1, 5);
        wait_empty("guard_first_run", 40);
        sb.push_back(ev_run(0, 4, 0));
        sb.push_back(ev_done(0, 1, 1));
        pulse_start();
        wait_empty("guard_entry_unchanged", 40);

        // Reset mid-run: outputs drop without a clock edge, table cleared.
        sb.push_back(ev_run(0, 4, 0));
        pulse_start();
        wait_enable("mid_reset_enable", 10);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_reset_busy", 32'(busy), 0);
        chk("mid_reset_enable", 32'(cnt_if.cnt_enable), 0);
        chk("mid_reset_clear_n", 32'(cnt_if.cnt_clear_n), 0);
        chk("mid_reset_period", 32'(cnt_if.cnt_period), 0);
        chk("mid_reset_step", 32'(step_idx), 0);
        chk("mid_reset_events", sb.size(), 0);
        sb.delete();
        #3;
        reset = 1'b1;
        sb.push_back(ev_done(0, 0, 0));
        pulse_start();
        wait_empty("table_cleared", 20);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
